// File: rtl/cell_resolver.sv
// Saper cell evaluator: resolves one reveal/flag action per request and counts
// adjacent mines with an 8-step neighbour scan. Result outputs are registered pulses.
module cell_resolver #(
    parameter int MAX_DIM = 16,
    parameter int IDX_W   = 5,
    parameter int CNT_W   = $clog2(MAX_DIM*MAX_DIM+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       op,
    input  logic [IDX_W-1:0]           x_in,
    input  logic [IDX_W-1:0]           y_in,
    input  logic [IDX_W-1:0]           board_size,
    input  logic [CNT_W-1:0]           mine_total,
    input  logic [MAX_DIM*MAX_DIM-1:0] mine_map,
    input  logic                       board_clear,
    output logic                       busy,
    output logic                       done,
    output logic                       explode,
    output logic                       defuse,
    output logic                       mark_flag,
    output logic                       unmark_flag,
    output logic                       blocked,
    output logic [3:0]                 neighbor_cnt,
    output logic [CNT_W-1:0]           flag_count,
    output logic [CNT_W-1:0]           revealed_count,
    output logic                       all_clear
);

    localparam int NCELL = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(NCELL);
    localparam int SW    = IDX_W + 1;
    localparam int TW    = ((2*IDX_W > CNT_W) ? 2*IDX_W : CNT_W) + 1;
    localparam logic [IDX_W:0] DIM_L = (IDX_W+1)'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, EVAL, SCAN} state_t;

    state_t             state_q, state_d;
    logic [NCELL-1:0]   flag_q, flag_d, rev_q, rev_d;
    logic [IDX_W-1:0]   x_q, x_d, y_q, y_d, size_q, size_d;
    logic               op_q, op_d;
    logic [2:0]         k_q, k_d;
    logic [3:0]         acc_q, acc_d, nbr_q, nbr_d;
    logic [CNT_W-1:0]   flag_cnt_q, flag_cnt_d, rev_cnt_q, rev_cnt_d;
    logic               done_q, done_d, explode_q, explode_d, defuse_q, defuse_d;
    logic               mark_q, mark_d, unmark_q, unmark_d, blocked_q, blocked_d;

    function automatic logic [AW-1:0] cell_idx(input logic [IDX_W-1:0] cx,
                                               input logic [IDX_W-1:0] cy);
        logic [IDX_W+AW-1:0] wide;
        wide = (IDX_W+AW)'(cy) * (IDX_W+AW)'(MAX_DIM) + (IDX_W+AW)'(cx);
        return AW'(wide);
    endfunction

    logic            cur_in;
    logic [AW-1:0]   cur_idx;
    assign cur_in  = ({1'b0, x_q} < {1'b0, size_q}) && ({1'b0, y_q} < {1'b0, size_q})
                  && ({1'b0, x_q} < DIM_L) && ({1'b0, y_q} < DIM_L);
    assign cur_idx = cell_idx(x_q, y_q);

    // Neighbour k offsets: dx = -1,0,+1,-1,+1,-1,0,+1 ; dy = -1,-1,-1,0,0,+1,+1,+1
    logic signed [SW-1:0] dx, dy, nx, ny;
    logic [SW-1:0]        nxu, nyu;
    logic                 n_in, n_mine;
    logic [AW-1:0]        n_idx;

    always_comb begin
        dx = '0;
        dy = '0;
        case (k_q)
            3'd0, 3'd3, 3'd5: dx = -SW'(1);
            3'd2, 3'd4, 3'd7: dx = SW'(1);
            default:          dx = '0;
        endcase
        case (k_q)
            3'd0, 3'd1, 3'd2: dy = -SW'(1);
            3'd5, 3'd6, 3'd7: dy = SW'(1);
            default:          dy = '0;
        endcase
        nx     = $signed({1'b0, x_q}) + dx;
        ny     = $signed({1'b0, y_q}) + dy;
        nxu    = nx;
        nyu    = ny;
        n_in   = !nx[SW-1] && !ny[SW-1]
              && (nxu < {1'b0, size_q}) && (nyu < {1'b0, size_q})
              && (nxu < DIM_L) && (nyu < DIM_L);
        n_idx  = cell_idx(nxu[IDX_W-1:0], nyu[IDX_W-1:0]);
        n_mine = n_in && mine_map[n_idx];
    end

    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        rev_d      = rev_q;
        x_d        = x_q;
        y_d        = y_q;
        size_d     = size_q;
        op_d       = op_q;
        k_d        = k_q;
        acc_d      = acc_q;
        nbr_d      = nbr_q;
        flag_cnt_d = flag_cnt_q;
        rev_cnt_d  = rev_cnt_q;
        done_d     = 1'b0;
        explode_d  = 1'b0;
        defuse_d   = 1'b0;
        mark_d     = 1'b0;
        unmark_d   = 1'b0;
        blocked_d  = 1'b0;

        if (board_clear) begin
            // Clear also aborts any action in flight and swallows a same-cycle req
            state_d    = IDLE;
            flag_d     = '0;
            rev_d      = '0;
            flag_cnt_d = '0;
            rev_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        x_d     = x_in;
                        y_d     = y_in;
                        op_d    = op;
                        size_d  = board_size;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!cur_in) begin
                        blocked_d = 1'b1;
                    end else if (op_q) begin
                        if (rev_q[cur_idx]) begin
                            blocked_d = 1'b1;
                        end else if (flag_q[cur_idx]) begin
                            flag_d[cur_idx] = 1'b0;
                            flag_cnt_d      = flag_cnt_q - CNT_W'(1);
                            unmark_d        = 1'b1;
                        end else begin
                            flag_d[cur_idx] = 1'b1;
                            flag_cnt_d      = flag_cnt_q + CNT_W'(1);
                            mark_d          = 1'b1;
                        end
                    end else if (flag_q[cur_idx] || rev_q[cur_idx]) begin
                        blocked_d = 1'b1;
                    end else if (mine_map[cur_idx]) begin
                        explode_d = 1'b1;
                    end else begin
                        rev_d[cur_idx] = 1'b1;
                        rev_cnt_d      = rev_cnt_q + CNT_W'(1);
                        k_d            = '0;
                        acc_d          = '0;
                        done_d         = 1'b0;
                        state_d        = SCAN;
                    end
                end
                SCAN: begin
                    acc_d = acc_q + {3'b000, n_mine};
                    k_d   = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        nbr_d    = acc_q + {3'b000, n_mine};
                        defuse_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flag_q     <= '0;
            rev_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            size_q     <= '0;
            op_q       <= 1'b0;
            k_q        <= '0;
            acc_q      <= '0;
            nbr_q      <= '0;
            flag_cnt_q <= '0;
            rev_cnt_q  <= '0;
            done_q     <= 1'b0;
            explode_q  <= 1'b0;
            defuse_q   <= 1'b0;
            mark_q     <= 1'b0;
            unmark_q   <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flag_q     <= flag_d;
            rev_q      <= rev_d;
            x_q        <= x_d;
            y_q        <= y_d;
            size_q     <= size_d;
            op_q       <= op_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            nbr_q      <= nbr_d;
            flag_cnt_q <= flag_cnt_d;
            rev_cnt_q  <= rev_cnt_d;
            done_q     <= done_d;
            explode_q  <= explode_d;
            defuse_q   <= defuse_d;
            mark_q     <= mark_d;
            unmark_q   <= unmark_d;
            blocked_q  <= blocked_d;
        end
    end

    // Safe-cell target goes non-positive on degenerate boards; never report clear then
    logic [2*IDX_W-1:0] size_sq;
    logic [TW-1:0]      sq_ext, mt_ext;
    assign size_sq = {{IDX_W{1'b0}}, board_size} * {{IDX_W{1'b0}}, board_size};
    assign sq_ext  = TW'(size_sq);
    assign mt_ext  = TW'(mine_total);
    assign all_clear = (sq_ext > mt_ext) && (TW'(rev_cnt_q) == (sq_ext - mt_ext));

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign explode        = explode_q;
    assign defuse         = defuse_q;
    assign mark_flag      = mark_q;
    assign unmark_flag    = unmark_q;
    assign blocked        = blocked_q;
    assign neighbor_cnt   = nbr_q;
    assign flag_count     = flag_cnt_q;
    assign revealed_count = rev_cnt_q;

endmodule

// File: tb/tb_cell_resolver.sv
// Table-driven bench for cell_resolver with a scoreboard queue of expected results,
// plus hand-written sequences for req-during-scan and board_clear corner cases.
module tb_cell_resolver;

    localparam int MAX_DIM = 16;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 9;

    localparam logic [4:0] R_EXP = 5'b10000;
    localparam logic [4:0] R_DEF = 5'b01000;
    localparam logic [4:0] R_MRK = 5'b00100;
    localparam logic [4:0] R_UNM = 5'b00010;
    localparam logic [4:0] R_BLK = 5'b00001;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       req;
    logic                       op;
    logic [IDX_W-1:0]           x_in, y_in, board_size;
    logic [CNT_W-1:0]           mine_total;
    logic [MAX_DIM*MAX_DIM-1:0] mine_map;
    logic                       board_clear;
    logic                       busy, done, explode, defuse, mark_flag, unmark_flag, blocked;
    logic [3:0]                 neighbor_cnt;
    logic [CNT_W-1:0]           flag_count, revealed_count;
    logic                       all_clear;

    cell_resolver #(.MAX_DIM(MAX_DIM), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .x_in(x_in), .y_in(y_in),
        .board_size(board_size), .mine_total(mine_total), .mine_map(mine_map),
        .board_clear(board_clear), .busy(busy), .done(done), .explode(explode),
        .defuse(defuse), .mark_flag(mark_flag), .unmark_flag(unmark_flag),
        .blocked(blocked), .neighbor_cnt(neighbor_cnt), .flag_count(flag_count),
        .revealed_count(revealed_count), .all_clear(all_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cfg;
        logic       op;
        int         x;
        int         y;
        logic [4:0] res;
        int         nbr;
        int         flags;
        int         revs;
        logic       allc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_cfg  = -1;

    function automatic vec_t mk(int cfg, logic o, int x, int y, logic [4:0] res,
                                int nbr, int flags, int revs, logic allc);
        vec_t v;
        v.cfg = cfg; v.op = o; v.x = x; v.y = y; v.res = res;
        v.nbr = nbr; v.flags = flags; v.revs = revs; v.allc = allc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setMine(input int x, input int y);
        mine_map[y*MAX_DIM + x] = 1'b1;
    endtask

    task automatic configure(input int cfg);
        mine_map = '0;
        case (cfg)
            0: begin
                board_size = 5'd8; mine_total = 9'd4;
                setMine(3, 2); setMine(0, 1); setMine(1, 0); setMine(1, 1);
                setMine(8, 7);
            end
            1: begin
                board_size = 5'd16; mine_total = 9'd40;
                for (int i = 0; i < 16; i++) begin
                    setMine(i, 5);
                    setMine(i, 7);
                end
                setMine(14, 14); setMine(15, 14); setMine(0, 0); setMine(0, 15);
                setMine(15, 0); setMine(0, 14); setMine(3, 10); setMine(4, 10);
            end
            default: begin
                board_size = 5'd2; mine_total = 9'd1;
                setMine(1, 1);
            end
        endcase
        board_clear = 1'b1;
        @(posedge clk); #1;
        board_clear = 1'b0;
        cur_cfg = cfg;
    endtask

    task automatic applyStimulus(input vec_t v);
        req  = 1'b1;
        op   = v.op;
        x_in = IDX_W'(v.x);
        y_in = IDX_W'(v.y);
        sb_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t       e;
        int         cyc;
        logic       got;
        logic [4:0] res;
        cyc = 0;
        got = 1'b0;
        res = '0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                req = 1'b0;
                check({tag, "_busy"}, int'(busy), 1);
            end
            if (done) begin
                got = 1'b1;
                res = {explode, defuse, mark_flag, unmark_flag, blocked};
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_result"}, int'(res), int'(e.res));
            check({tag, "_latency"}, cyc, (e.res == R_DEF) ? 10 : 2);
            if (e.res == R_DEF)
                check({tag, "_nbr"}, int'(neighbor_cnt), e.nbr);
            check({tag, "_flags"}, int'(flag_count), e.flags);
            check({tag, "_revs"}, int'(revealed_count), e.revs);
            check({tag, "_allclear"}, int'(all_clear), int'(e.allc));
        end
    endtask

    initial begin
        int nd, dc, def_seen;

        rst = 1'b1; req = 1'b0; op = 1'b0; x_in = '0; y_in = '0;
        board_size = 5'd8; mine_total = 9'd4; mine_map = '0; board_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pulses", int'({explode, defuse, mark_flag, unmark_flag, blocked}), 0);
        check("reset_nbr", int'(neighbor_cnt), 0);
        check("reset_flags", int'(flag_count), 0);
        check("reset_revs", int'(revealed_count), 0);
        rst = 1'b0;

        // 8x8 board, mines (3,2),(0,1),(1,0),(1,1), plus a stray map bit at (8,7)
        vecs.push_back(mk(0, 0, 3, 2, R_EXP, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, R_DEF, 3, 0, 1, 0));
        vecs.push_back(mk(0, 1, 5, 5, R_MRK, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 5, 5, R_BLK, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5, 5, R_UNM, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 9, 9, R_BLK, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, R_BLK, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, R_BLK, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 4, 2, R_DEF, 1, 0, 2, 0));
        vecs.push_back(mk(0, 0, 7, 7, R_DEF, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 8, 0, R_BLK, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 7, R_DEF, 0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 2, R_DEF, 2, 0, 5, 0));
        // 16x16 board, 40 mines; corner reveal must not wrap
        vecs.push_back(mk(1, 0, 15, 15, R_DEF, 2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 15, R_EXP, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 3, 10, R_MRK, 0, 1, 1, 0));
        // 2x2 board with one mine at (1,1)
        vecs.push_back(mk(2, 0, 0, 0, R_DEF, 1, 0, 1, 0));
        vecs.push_back(mk(2, 0, 1, 0, R_DEF, 1, 0, 2, 0));
        vecs.push_back(mk(2, 0, 0, 1, R_DEF, 1, 0, 3, 1));
        vecs.push_back(mk(2, 1, 1, 1, R_MRK, 0, 1, 3, 1));
        vecs.push_back(mk(2, 0, 1, 1, R_BLK, 0, 1, 3, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].cfg != cur_cfg) begin
                if (vecs[i].cfg == 2) begin
                    // A req issued while SCAN is running must be dropped, not queued
                    req = 1'b1; op = 1'b0; x_in = 5'd10; y_in = 5'd10;
                    nd = 0; dc = 0; def_seen = 0;
                    for (int c = 1; c <= 14; c++) begin
                        @(posedge clk); #1;
                        if (c == 1) req = 1'b0;
                        if (c == 3) begin req = 1'b1; op = 1'b1; x_in = 5'd2; y_in = 5'd2; end
                        if (c == 4) req = 1'b0;
                        if (done) begin
                            nd++;
                            if (dc == 0) begin dc = c; def_seen = int'(defuse); end
                        end
                    end
                    check("scan_req_done_cycle", dc, 10);
                    check("scan_req_done_count", nd, 1);
                    check("scan_req_defuse", def_seen, 1);
                    check("scan_req_nbr", int'(neighbor_cnt), 0);
                    check("scan_req_flags", int'(flag_count), 1);
                    check("scan_req_revs", int'(revealed_count), 2);
                end
                configure(vecs[i].cfg);
            end
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // board_clear in the middle of a SCAN aborts it silently
        configure(2);
        check("clear_allclear", int'(all_clear), 0);
        applyStimulus(mk(2, 1, 1, 1, R_MRK, 0, 1, 0, 0));
        checkOutput("clr_flag");
        req = 1'b1; op = 1'b0; x_in = 5'd0; y_in = 5'd0;
        nd = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 1) req = 1'b0;
            if (c == 3) board_clear = 1'b1;
            if (c == 4) board_clear = 1'b0;
            if (done) nd++;
        end
        check("midscan_clear_dones", nd, 0);
        check("midscan_clear_flags", int'(flag_count), 0);
        check("midscan_clear_revs", int'(revealed_count), 0);
        check("midscan_clear_allclear", int'(all_clear), 0);
        check("midscan_clear_busy", int'(busy), 0);

        // board_clear and req together: the clear wins
        req = 1'b1; board_clear = 1'b1; op = 1'b0; x_in = 5'd0; y_in = 5'd0;
        nd = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req = 1'b0; board_clear = 1'b0;
                check("clear_req_busy", int'(busy), 0);
            end
            if (done) nd++;
        end
        check("clear_req_dones", nd, 0);
        check("clear_req_revs", int'(revealed_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
